// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Arbitrates a single SDRAM command engine between auto-refresh, the camera
// write path and the VGA line-buffer read path.
//
// Priority in IDLE: pending refresh > starved write (wr_wait at WR_WAIT_MAX)
// > read > write. A grant is held until the command engine pulses op_done.
// The arbiter then idles for TURN_CYC cycles before it can grant again.
//
// Parameters
//   REF_PERIOD  : refresh interval in CLK cycles
//   TURN_CYC    : idle turnaround cycles after every operation (1..15)
//   WR_WAIT_MAX : write-wait cycles after which a write outranks a read
// Ports
//   CLK       in  system clock, rising edge
//   RSTn      in  asynchronous active-low reset
//   init_done in  SDRAM power-up init complete (level)
//   rd_req    in  read burst request (level)
//   wr_req    in  write burst request (level)
//   op_done   in  one-cycle pulse: granted operation finished
//   rd_gnt    out read grant
//   wr_gnt    out write grant
//   ref_gnt   out auto-refresh grant
//   busy      out high whenever the FSM is not in IDLE
//   ref_miss  out sticky: a refresh interval expired with a refresh still pending
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int REF_PERIOD  = 780,
    parameter int TURN_CYC    = 2,
    parameter int WR_WAIT_MAX = 64
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic init_done,
    input  logic rd_req,
    input  logic wr_req,
    input  logic op_done,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic ref_gnt,
    output logic busy,
    output logic ref_miss
);

    localparam int RC_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int WW_W = $clog2(WR_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_REF = 3'd1,
        GNT_RD  = 3'd2,
        GNT_WR  = 3'd3,
        TURN    = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [RC_W-1:0]   ref_cnt_reg;
    logic              ref_pending_reg;
    logic [WW_W-1:0]   wr_wait_reg;
    logic [3:0]        turn_cnt_reg;
    // Goes high on the first edge after reset release; grants are blocked
    // until then so the first grant can never coincide with that edge.
    logic              run_reg;

    logic ref_wrap;
    logic ref_done;
    logic wr_rise;

    assign ref_wrap = init_done && (ref_cnt_reg == RC_W'(REF_PERIOD - 1));
    assign ref_done = (state_reg == GNT_REF) && op_done;
    assign wr_rise  = (state_next == GNT_WR) && (state_reg != GNT_WR);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (init_done && run_reg) begin
                    if (ref_pending_reg)
                        state_next = GNT_REF;
                    else if (wr_req && (wr_wait_reg == WW_W'(WR_WAIT_MAX)))
                        state_next = GNT_WR;
                    else if (rd_req)
                        state_next = GNT_RD;
                    else if (wr_req)
                        state_next = GNT_WR;
                end
            end
            GNT_REF, GNT_RD, GNT_WR: begin
                if (op_done)
                    state_next = TURN;
            end
            TURN: begin
                if (turn_cnt_reg == 4'(TURN_CYC - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Losing init overrides everything, including an in-flight grant.
        if (!init_done)
            state_next = IDLE;
    end

    // State and registered outputs (grants decoded from the next state so
    // they change on the same edge as the state register).
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= IDLE;
            rd_gnt    <= 1'b0;
            wr_gnt    <= 1'b0;
            ref_gnt   <= 1'b0;
            busy      <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rd_gnt    <= (state_next == GNT_RD);
            wr_gnt    <= (state_next == GNT_WR);
            ref_gnt   <= (state_next == GNT_REF);
            busy      <= (state_next != IDLE);
            run_reg   <= 1'b1;
        end
    end

    // Turnaround counter: counts cycles spent in TURN, zero elsewhere.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            turn_cnt_reg <= 4'd0;
        else if (state_reg == TURN)
            turn_cnt_reg <= turn_cnt_reg + 4'd1;
        else
            turn_cnt_reg <= 4'd0;
    end

    // Refresh interval timer, pending flag and sticky miss flag.
    // A wrap that lands on the op_done of the current refresh simply
    // re-arms the pending flag; that refresh was serviced, so no miss.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
            ref_miss        <= 1'b0;
        end else if (!init_done) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
        end else begin
            if (ref_wrap) begin
                ref_cnt_reg     <= '0;
                ref_pending_reg <= 1'b1;
                if (ref_pending_reg && !ref_done)
                    ref_miss <= 1'b1;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + RC_W'(1);
                if (ref_done)
                    ref_pending_reg <= 1'b0;
            end
        end
    end

    // Write starvation counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            wr_wait_reg <= '0;
        else if (wr_rise)
            wr_wait_reg <= '0;
        else if (wr_req && !wr_gnt && (wr_wait_reg != WW_W'(WR_WAIT_MAX)))
            wr_wait_reg <= wr_wait_reg + WW_W'(1);
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter with default parameters. Expected grant
// events (kind + edge number after reset release) are queued up front; a
// monitor thread pops one entry on every rising grant and compares. Direct
// level checks cover held grants, busy, ref_miss and reset behaviour.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    logic CLK = 1'b0;
    logic RSTn = 1'b1;
    logic init_done = 1'b0;
    logic rd_req = 1'b0;
    logic wr_req = 1'b0;
    logic op_man = 1'b0;
    logic op_auto = 1'b0;
    logic op_done;
    logic rd_gnt, wr_gnt, ref_gnt, busy, ref_miss;

    assign op_done = op_man | op_auto;

    sdram_arbiter #(
        .REF_PERIOD (780),
        .TURN_CYC   (2),
        .WR_WAIT_MAX(64)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .init_done(init_done),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .op_done  (op_done),
        .rd_gnt   (rd_gnt),
        .wr_gnt   (wr_gnt),
        .ref_gnt  (ref_gnt),
        .busy     (busy),
        .ref_miss (ref_miss)
    );

    always #5 CLK = ~CLK;

    // Edge number since reset release: at the negedge after edge k, rel == k.
    int rel;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) rel <= 0;
        else       rel <= rel + 1;
    end

    // Auto responder: pulses op_done so it is sampled op_lat edges after the grant.
    logic auto_en = 1'b0;
    int   op_lat  = 10;
    int   resp_cnt;
    logic resp_prev;
    always @(negedge CLK) begin
        resp_prev <= rd_gnt | wr_gnt | ref_gnt;
        if (!auto_en || !(rd_gnt | wr_gnt | ref_gnt)) begin
            resp_cnt <= 0;
            op_auto  <= 1'b0;
        end else if (!resp_prev) begin
            resp_cnt <= op_lat - 1;
            op_auto  <= (op_lat == 1);
        end else if (resp_cnt != 0) begin
            resp_cnt <= resp_cnt - 1;
            op_auto  <= (resp_cnt == 1);
        end else begin
            op_auto  <= 1'b0;
        end
    end

    // Scoreboard
    typedef struct {
        int kind;     // 0 = read, 1 = write, 2 = refresh
        int at_edge;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit done  = 1'b0;

    function automatic void check(string name, int act, int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, rel);
        end else begin
            $display("ok   %s = %0d (edge %0d)", name, act, rel);
        end
    endfunction

    function automatic void expect_gnt(int kind, int at_edge);
        exp_t e;
        e.kind    = kind;
        e.at_edge = at_edge;
        exp_q.push_back(e);
    endfunction

    task automatic monitor();
        logic [2:0] prev;
        logic [2:0] g;
        logic [2:0] rising;
        logic [2:0] want;
        exp_t       e;
        prev = 3'b000;
        while (!done) begin
            @(negedge CLK);
            g = {ref_gnt, wr_gnt, rd_gnt};
            if ($countones(g) > 1) begin
                n_vec++;
                n_err++;
                $display("FAIL onehot: grants %b, expected at most one high (edge %0d)", g, rel);
            end
            rising = g & ~prev;
            if (rising != 3'b000) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant: unexpected grant %b at edge %0d, expected none", rising, rel);
                end else begin
                    e    = exp_q.pop_front();
                    want = 3'b001 << e.kind;
                    if (rising != want || rel != e.at_edge) begin
                        n_err++;
                        $display("FAIL grant: got %b at edge %0d, expected %b at edge %0d",
                                 rising, rel, want, e.at_edge);
                    end else begin
                        $display("ok   grant %b at edge %0d", rising, rel);
                    end
                end
            end
            prev = g;
        end
    endtask

    task automatic wait_rel(int k);
        int guard;
        guard = 0;
        while (rel < k) begin
            @(negedge CLK);
            guard++;
            if (guard > 5000) begin
                $display("FAIL wait_rel: edge %0d not reached, stuck at %0d", k, rel);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn      = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        init_done = 1'b0;
        op_man    = 1'b0;
        auto_en   = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_tests();
        // ---- reset state and init_done=0 holding IDLE ----
        do_reset();
        check("rst_rd_gnt", rd_gnt, 0);
        check("rst_wr_gnt", wr_gnt, 0);
        check("rst_ref_gnt", ref_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ref_miss", ref_miss, 0);
        rd_req = 1'b1;
        wr_req = 1'b1;
        RSTn   = 1'b1;
        wait_rel(20);
        check("noinit_busy", busy, 0);
        check("noinit_queue", exp_q.size(), 0);

        // ---- refresh only: grant at 781, op_done at 789, TURN, op_done ignored ----
        do_reset();
        init_done = 1'b1;
        RSTn      = 1'b1;
        expect_gnt(2, 781);
        wait_rel(780);
        check("ref_pre_busy", busy, 0);
        wait_rel(788);
        check("ref_held", ref_gnt, 1);
        op_man = 1'b1;              // sampled at 789 (GNT_REF) and 790 (TURN)
        wait_rel(789);
        check("ref_drop", ref_gnt, 0);
        check("ref_turn1_busy", busy, 1);
        wait_rel(790);
        op_man = 1'b0;
        check("ref_turn2_busy", busy, 1);
        wait_rel(791);
        check("ref_idle_busy", busy, 0);
        wait_rel(792);
        op_man = 1'b1;              // sampled at 793 in IDLE
        wait_rel(793);
        op_man = 1'b0;
        check("idle_opdone_busy", busy, 0);
        wait_rel(796);
        check("idle_opdone_busy2", busy, 0);
        check("ref_miss_clear", ref_miss, 0);
        check("ref_queue", exp_q.size(), 0);

        // ---- read vs write with starvation promotion ----
        do_reset();
        init_done = 1'b1;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        op_lat    = 10;
        auto_en   = 1'b1;
        RSTn      = 1'b1;
        expect_gnt(0, 2);
        expect_gnt(0, 15);
        expect_gnt(0, 28);
        expect_gnt(0, 41);
        expect_gnt(0, 54);
        expect_gnt(1, 67);
        expect_gnt(0, 80);
        wait_rel(66);
        check("arb_idle_busy", busy, 0);
        wait_rel(67);
        check("arb_wr_gnt", wr_gnt, 1);
        check("arb_rd_off", rd_gnt, 0);
        wait_rel(85);
        check("arb_rd_again", rd_gnt, 1);
        check("arb_queue", exp_q.size(), 0);
        auto_en = 1'b0;

        // ---- long read, refresh miss, refresh wins, init drop, reset mid-read ----
        do_reset();
        init_done = 1'b1;
        rd_req    = 1'b1;
        RSTn      = 1'b1;
        expect_gnt(0, 2);
        expect_gnt(2, 1603);
        expect_gnt(0, 1613);
        expect_gnt(0, 1617);
        wait_rel(1559);
        check("miss_before", ref_miss, 0);
        wait_rel(1560);
        check("miss_after", ref_miss, 1);
        wait_rel(1599);
        check("long_rd_held", rd_gnt, 1);
        op_man = 1'b1;
        wait_rel(1600);
        op_man = 1'b0;
        check("long_rd_drop", rd_gnt, 0);
        wait_rel(1603);
        check("ref_first", ref_gnt, 1);
        check("ref_first_rd", rd_gnt, 0);
        wait_rel(1609);
        op_man = 1'b1;
        wait_rel(1610);
        op_man = 1'b0;
        wait_rel(1615);
        check("rd_before_drop", rd_gnt, 1);
        init_done = 1'b0;
        wait_rel(1616);
        check("initdrop_rd", rd_gnt, 0);
        check("initdrop_busy", busy, 0);
        check("initdrop_miss_kept", ref_miss, 1);
        init_done = 1'b1;
        wait_rel(1618);
        check("rd_after_init", rd_gnt, 1);
        RSTn = 1'b0;
        #1;
        check("async_rst_rd", rd_gnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_miss", ref_miss, 0);
        check("miss_queue", exp_q.size(), 0);

        // ---- write request dropped during grant, init drop mid-write ----
        do_reset();
        init_done = 1'b1;
        wr_req    = 1'b1;
        op_lat    = 6;
        auto_en   = 1'b1;
        RSTn      = 1'b1;
        expect_gnt(1, 2);
        expect_gnt(1, 13);
        wait_rel(3);
        wr_req = 1'b0;
        wait_rel(7);
        check("wr_held_noreq", wr_gnt, 1);
        wait_rel(8);
        check("wr_drop", wr_gnt, 0);
        check("wr_turn_busy", busy, 1);
        wait_rel(12);
        wr_req = 1'b1;
        wait_rel(15);
        check("wr2_held", wr_gnt, 1);
        init_done = 1'b0;
        wait_rel(16);
        check("wr_initdrop", wr_gnt, 0);
        check("wr_initdrop_busy", busy, 0);
        wait_rel(20);
        check("wr_noinit_busy", busy, 0);
        check("wr_queue", exp_q.size(), 0);
        auto_en = 1'b0;
        done    = 1'b1;
    endtask

    initial begin
        do_reset();
        fork
            monitor();
            run_tests();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
